ysyx_22050710_id_stage: RTL and testbench
=========================================

Name: ysyx_22050710_id_stage

Overview:
- Pipelined, parametrised RV32I/RV64I instruction decode stage between IFU and EXU.
- Accepts {pc, inst} from the IFU over a valid/ready handshake and decodes it.
- Buffers decoded bundles in a DEPTH-entry FIFO and presents the head bundle to the EXU over a second valid/ready handshake.
- Adds full base-ISA coverage (shifts, logic ops, signed branches, all load/store widths), illegal-instruction flagging and pipeline flush.

Parameters:
- XLEN, 64, datapath width; legal values 32 or 64. XLEN=32 makes RV64-only encodings illegal.
- DEPTH, 2, decoded-bundle FIFO entries; power of two, minimum 2.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_flush  in  1  discard all buffered bundles and the input beat of the same cycle.
- i_valid  in  1  IFU beat valid.
- o_ready  out  1  stage can accept a beat.
- i_pc  in  XLEN  instruction PC.
- i_inst  in  32  instruction word.
- o_valid  out  1  head bundle valid.
- i_ready  in  1  EXU accepts head bundle.
- o_pc  out  XLEN  PC of head bundle.
- o_imm  out  XLEN  sign-extended immediate.
- o_ra, o_rb, o_rd  out  5 each  register indices.
- o_Branch  out  3  000 none, 001 jal, 010 jalr, 100 beq, 101 bne, 110 blt/bltu, 111 bge/bgeu.
- o_ALUAsrc  out  1  0 = rs1, 1 = PC.
- o_ALUBsrc  out  2  00 = rs2, 01 = imm, 10 = constant 4.
- o_ALUctr  out  4  0000 add, 1000 sub, 0001 sll, 0010 slt, 1010 sltu, 0100 xor, 0101 srl, 1101 sra, 0110 or, 0111 and, 0011 copyimm, 1110 ebreak, 1111 none.
- o_word_cut  out  1  32-bit op with sign-extended result (the *W forms).
- o_RegWr, o_MemtoReg, o_MemWr  out  1 each  writeback, load-select and store enables.
- o_MemOP  out  3  000 sb/lb, 001 lbu, 010 sh/lh, 011 lhu, 100 sw/lw, 101 lwu, 110 sd/ld, 111 none.
- o_illegal  out  1  head bundle is an unrecognised encoding.
- o_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (asynchronous, i_rst_n=0):
  - Read/write pointers and count clear to 0; o_valid=0.
  - All bundle outputs read 0. o_ALUctr reads 1111 and o_MemOP reads 111 while empty.
- Handshake:
  - Push when i_valid & o_ready. Pop when o_valid & i_ready.
  - o_ready = (count != DEPTH). It depends only on registered state; there is no combinational path from i_ready.
  - o_valid = (count != 0).
  - Full with simultaneous pop: o_ready is still 0, so no push occurs.
  - Push and pop in the same cycle leave count unchanged.
- Latency: a beat pushed at edge N appears at the outputs after edge N (one cycle) when the FIFO was empty.
- Ordering: in-order FIFO; pointers wrap modulo DEPTH.
- Decode:
  - Decode is combinational on {i_pc, i_inst} at push, and the full bundle is stored.
  - Output fields are driven directly from the head entry.
- Immediates: I, S, B, U and J formats are sign-extended from inst[31] to XLEN. U-type is {inst[31:12], 12'b0} sign-extended.
- Shift immediates: shamt = inst[25:20] when XLEN=64. When XLEN=32, inst[25]=1 is illegal.
- ALU source selection:
  - auipc, jal and jalr set ALUAsrc=1.
  - jal and jalr set ALUBsrc=10.
  - Other I, S and U types set ALUBsrc=01; R and B types set ALUBsrc=00.
- ALU control:
  - lui: ALUctr 0011.
  - Loads, stores, auipc, jal, jalr: ALUctr 0000.
  - beq/bne use 1000, blt/bge use 0010, bltu/bgeu use 1010.
- RV64 word ops (addiw/slliw/srliw/sraiw/addw/subw/sllw/srlw/sraw) and lwu/ld/sd:
  - Legal only when XLEN=64; word ops set o_word_cut=1.
  - When XLEN=32 they are illegal.
- ebreak (0x00100073): ALUctr=1110, RegWr=0, o_illegal=0.
- Illegal encodings (any unlisted opcode/funct3/funct7 combination):
  - o_illegal=1, RegWr=0, MemWr=0, MemtoReg=0, Branch=000, ALUctr=1111, MemOP=111.
  - The bundle still flows through the FIFO in order.
- Flush (i_flush=1 at an edge):
  - Count and pointers clear; o_valid=0 from the next cycle.
  - A push or pop in the same cycle is discarded.
  - Flush overrides all other events.
- Reset asserted mid-operation discards all content immediately. After release, the first push behaves as if from an empty FIFO.

Test Plan:
- Reset, then push addi x1,x0,-1 (0xFFF00093) -> o_valid=1 one cycle later; o_imm=0xFFFF_FFFF_FFFF_FFFF, ALUctr=0000, ALUBsrc=01, RegWr=1, o_rd=1.
- Push 3 beats with i_ready=0 and DEPTH=2 -> o_ready=0 after 2 pushes and o_count=2. Then raise i_ready -> bundles pop in order with matching o_pc values.
- blt x1,x2,-4 (0xFE20CEE3) -> o_Branch=110, ALUctr=0010, o_imm=-4, RegWr=0. bgeu (0xFE20FEE3) -> o_Branch=111, ALUctr=1010.
- XLEN=32: addw (0x002080BB) -> o_illegal=1, RegWr=0. XLEN=64: same word -> o_word_cut=1, ALUctr=0000, o_illegal=0.
- lbu x3,8(x1) (0x0080C183) -> MemOP=001, MemtoReg=1. sd x2,16(x1) (0x0020B823) -> MemOP=110, MemWr=1, o_imm=16.
- Fill the FIFO, then assert i_flush together with i_valid -> next cycle o_valid=0 and o_count=0; the same-cycle input is not stored.

Source files
------------

// File: rtl/ysyx_22050710_id_stage.sv
// RV32I/RV64I decode stage: decodes IFU beats on push and queues the decoded bundles
// in a small FIFO that feeds the EXU over a valid/ready handshake.
module ysyx_22050710_id_stage #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_flush,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [XLEN-1:0]          i_pc,
  input  logic [31:0]              i_inst,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [XLEN-1:0]          o_pc,
  output logic [XLEN-1:0]          o_imm,
  output logic [4:0]               o_ra,
  output logic [4:0]               o_rb,
  output logic [4:0]               o_rd,
  output logic [2:0]               o_Branch,
  output logic                     o_ALUAsrc,
  output logic [1:0]               o_ALUBsrc,
  output logic [3:0]               o_ALUctr,
  output logic                     o_word_cut,
  output logic                     o_RegWr,
  output logic                     o_MemtoReg,
  output logic                     o_MemWr,
  output logic [2:0]               o_MemOP,
  output logic                     o_illegal,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam bit          Rv64 = (XLEN == 64);
  localparam logic [AW:0] Full = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [4:0]      ra;
    logic [4:0]      rb;
    logic [4:0]      rd;
    logic [2:0]      branch;
    logic            a_src;
    logic [1:0]      b_src;
    logic [3:0]      alu_ctr;
    logic            word_cut;
    logic            reg_wr;
    logic            mem_to_reg;
    logic            mem_wr;
    logic [2:0]      mem_op;
    logic            illegal;
  } bundle_t;

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [3:0]  base_ctr;
  logic        shamt_ok;
  logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  bundle_t     dec;

  assign opcode   = i_inst[6:0];
  assign funct3   = i_inst[14:12];
  assign funct7   = i_inst[31:25];
  assign base_ctr = (funct3 == 3'b011) ? 4'b1010 : {1'b0, funct3};
  // On RV32 the shamt is 5 bits, so inst[25] must be clear.
  assign shamt_ok = Rv64 || !i_inst[25];

  assign imm_i = {{52{i_inst[31]}}, i_inst[31:20]};
  assign imm_s = {{52{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
  assign imm_b = {{52{i_inst[31]}}, i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
  assign imm_u = {{32{i_inst[31]}}, i_inst[31:12], 12'b0};
  assign imm_j = {{44{i_inst[31]}}, i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

  always_comb begin
    dec         = '0;
    dec.pc      = i_pc;
    dec.ra      = i_inst[19:15];
    dec.rb      = i_inst[24:20];
    dec.rd      = i_inst[11:7];
    dec.alu_ctr = 4'b1111;
    dec.mem_op  = 3'b111;
    dec.illegal = 1'b1;
    case (opcode)
      7'b0110111: begin // lui
        dec.illegal = 1'b0; dec.imm = imm_u[XLEN-1:0]; dec.b_src = 2'b01;
        dec.alu_ctr = 4'b0011; dec.reg_wr = 1'b1;
      end
      7'b0010111: begin // auipc
        dec.illegal = 1'b0; dec.imm = imm_u[XLEN-1:0]; dec.a_src = 1'b1; dec.b_src = 2'b01;
        dec.alu_ctr = 4'b0000; dec.reg_wr = 1'b1;
      end
      7'b1101111: begin // jal
        dec.illegal = 1'b0; dec.imm = imm_j[XLEN-1:0]; dec.a_src = 1'b1; dec.b_src = 2'b10;
        dec.alu_ctr = 4'b0000; dec.branch = 3'b001; dec.reg_wr = 1'b1;
      end
      7'b1100111: begin // jalr
        dec.illegal = (funct3 != 3'b000); dec.imm = imm_i[XLEN-1:0]; dec.a_src = 1'b1;
        dec.b_src = 2'b10; dec.alu_ctr = 4'b0000; dec.branch = 3'b010; dec.reg_wr = 1'b1;
      end
      7'b1100011: begin // branches: funct3 010/011 are unassigned
        dec.illegal = (funct3[2:1] == 2'b01);
        dec.imm     = imm_b[XLEN-1:0];
        dec.branch  = {1'b1, funct3[2], funct3[0]};
        dec.alu_ctr = !funct3[2] ? 4'b1000 : (!funct3[1] ? 4'b0010 : 4'b1010);
      end
      7'b0000011: begin // loads
        dec.imm = imm_i[XLEN-1:0]; dec.b_src = 2'b01; dec.alu_ctr = 4'b0000;
        dec.reg_wr = 1'b1; dec.mem_to_reg = 1'b1;
        case (funct3)
          3'b000:  begin dec.illegal = 1'b0;  dec.mem_op = 3'b000; end
          3'b100:  begin dec.illegal = 1'b0;  dec.mem_op = 3'b001; end
          3'b001:  begin dec.illegal = 1'b0;  dec.mem_op = 3'b010; end
          3'b101:  begin dec.illegal = 1'b0;  dec.mem_op = 3'b011; end
          3'b010:  begin dec.illegal = 1'b0;  dec.mem_op = 3'b100; end
          3'b110:  begin dec.illegal = !Rv64; dec.mem_op = 3'b101; end
          3'b011:  begin dec.illegal = !Rv64; dec.mem_op = 3'b110; end
          default: dec.illegal = 1'b1;
        endcase
      end
      7'b0100011: begin // stores
        dec.imm = imm_s[XLEN-1:0]; dec.b_src = 2'b01; dec.alu_ctr = 4'b0000; dec.mem_wr = 1'b1;
        case (funct3)
          3'b000:  begin dec.illegal = 1'b0;  dec.mem_op = 3'b000; end
          3'b001:  begin dec.illegal = 1'b0;  dec.mem_op = 3'b010; end
          3'b010:  begin dec.illegal = 1'b0;  dec.mem_op = 3'b100; end
          3'b011:  begin dec.illegal = !Rv64; dec.mem_op = 3'b110; end
          default: dec.illegal = 1'b1;
        endcase
      end
      7'b0010011: begin // op-imm
        dec.imm = imm_i[XLEN-1:0]; dec.b_src = 2'b01; dec.reg_wr = 1'b1;
        dec.alu_ctr = base_ctr; dec.illegal = 1'b0;
        if (funct3 == 3'b001) begin
          dec.illegal = !((i_inst[31:26] == 6'b0) && shamt_ok);
        end else if (funct3 == 3'b101) begin
          dec.alu_ctr = {i_inst[30], funct3};
          dec.illegal = !(!i_inst[31] && (i_inst[29:26] == 4'b0) && shamt_ok);
        end
      end
      7'b0011011: begin // op-imm-32
        dec.imm = imm_i[XLEN-1:0]; dec.b_src = 2'b01; dec.reg_wr = 1'b1; dec.word_cut = 1'b1;
        dec.alu_ctr = {i_inst[30] && (funct3 == 3'b101), funct3};
        case (funct3)
          3'b000:  dec.illegal = !Rv64;
          3'b001:  dec.illegal = !(Rv64 && (funct7 == 7'b0));
          3'b101:  dec.illegal = !(Rv64 && !funct7[6] && (funct7[4:0] == 5'b0));
          default: dec.illegal = 1'b1;
        endcase
      end
      7'b0110011: begin // op
        dec.reg_wr = 1'b1;
        if (funct7 == 7'b0000000) begin
          dec.illegal = 1'b0; dec.alu_ctr = base_ctr;
        end else if (funct7 == 7'b0100000) begin
          dec.illegal = !((funct3 == 3'b000) || (funct3 == 3'b101));
          dec.alu_ctr = {1'b1, funct3};
        end
      end
      7'b0111011: begin // op-32
        dec.reg_wr = 1'b1; dec.word_cut = 1'b1; dec.alu_ctr = {funct7[5], funct3};
        dec.illegal = !(Rv64 &&
          (((funct7 == 7'b0) && ((funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b101))) ||
           ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)))));
      end
      7'b1110011: begin
        if (i_inst == 32'h0010_0073) begin
          dec.illegal = 1'b0; dec.alu_ctr = 4'b1110;
        end
      end
      default: ;
    endcase
    // Illegal encodings travel as inert bubbles so ordering is preserved.
    if (dec.illegal) begin
      dec.reg_wr = 1'b0; dec.mem_wr = 1'b0; dec.mem_to_reg = 1'b0; dec.branch = 3'b000;
      dec.alu_ctr = 4'b1111; dec.mem_op = 3'b111; dec.word_cut = 1'b0;
      dec.a_src = 1'b0; dec.b_src = 2'b00;
    end
  end

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  bundle_t       mem_q [DEPTH];
  bundle_t       head;
  logic          push, pop;

  assign o_ready = (count_q != Full);
  assign o_valid = (count_q != '0);
  assign o_count = count_q;
  assign push    = i_valid && o_ready;
  assign pop     = o_valid && i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (i_flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push && !i_flush) mem_q[wr_ptr_q] <= dec;
  end

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    o_pc       = '0;
    o_imm      = '0;
    o_ra       = '0;
    o_rb       = '0;
    o_rd       = '0;
    o_Branch   = '0;
    o_ALUAsrc  = 1'b0;
    o_ALUBsrc  = '0;
    o_ALUctr   = 4'b1111;
    o_word_cut = 1'b0;
    o_RegWr    = 1'b0;
    o_MemtoReg = 1'b0;
    o_MemWr    = 1'b0;
    o_MemOP    = 3'b111;
    o_illegal  = 1'b0;
    if (o_valid) begin
      o_pc       = head.pc;
      o_imm      = head.imm;
      o_ra       = head.ra;
      o_rb       = head.rb;
      o_rd       = head.rd;
      o_Branch   = head.branch;
      o_ALUAsrc  = head.a_src;
      o_ALUBsrc  = head.b_src;
      o_ALUctr   = head.alu_ctr;
      o_word_cut = head.word_cut;
      o_RegWr    = head.reg_wr;
      o_MemtoReg = head.mem_to_reg;
      o_MemWr    = head.mem_wr;
      o_MemOP    = head.mem_op;
      o_illegal  = head.illegal;
    end
  end

endmodule

// File: tb/tb_ysyx_22050710_id_stage.sv
// Directed bench for the decode stage: a decode vector table checked on an RV64 and an
// RV32 instance, plus hand sequences for backpressure, flush and mid-run reset.
module tb_ysyx_22050710_id_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [63:0] pc;
  logic [31:0] inst;

  logic        ready, valid, wcut, regwr, m2r, memwr, asrc, ill;
  logic [63:0] opc, imm;
  logic [4:0]  ra, rb, rd;
  logic [2:0]  br, memop;
  logic [1:0]  bsrc, cnt;
  logic [3:0]  ctr;

  logic        ready32, valid32, wcut32, regwr32, m2r32, memwr32, asrc32, ill32;
  logic [31:0] opc32, imm32;
  logic [4:0]  ra32, rb32, rd32;
  logic [2:0]  br32, memop32;
  logic [1:0]  bsrc32, cnt32;
  logic [3:0]  ctr32;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ysyx_22050710_id_stage #(.XLEN(64), .DEPTH(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(in_valid), .o_ready(ready),
    .i_pc(pc), .i_inst(inst), .o_valid(valid), .i_ready(out_ready), .o_pc(opc), .o_imm(imm),
    .o_ra(ra), .o_rb(rb), .o_rd(rd), .o_Branch(br), .o_ALUAsrc(asrc), .o_ALUBsrc(bsrc),
    .o_ALUctr(ctr), .o_word_cut(wcut), .o_RegWr(regwr), .o_MemtoReg(m2r), .o_MemWr(memwr),
    .o_MemOP(memop), .o_illegal(ill), .o_count(cnt)
  );

  ysyx_22050710_id_stage #(.XLEN(32), .DEPTH(2)) dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(in_valid), .o_ready(ready32),
    .i_pc(pc[31:0]), .i_inst(inst), .o_valid(valid32), .i_ready(out_ready), .o_pc(opc32),
    .o_imm(imm32), .o_ra(ra32), .o_rb(rb32), .o_rd(rd32), .o_Branch(br32),
    .o_ALUAsrc(asrc32), .o_ALUBsrc(bsrc32), .o_ALUctr(ctr32), .o_word_cut(wcut32),
    .o_RegWr(regwr32), .o_MemtoReg(m2r32), .o_MemWr(memwr32), .o_MemOP(memop32),
    .o_illegal(ill32), .o_count(cnt32)
  );

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] imm;
    logic [4:0]  rd;
    logic [2:0]  br;
    logic        asrc;
    logic [1:0]  bsrc;
    logic [3:0]  ctr;
    logic        wcut;
    logic        regwr;
    logic        m2r;
    logic        memwr;
    logic [2:0]  memop;
    logic        ill;
    logic        ill32;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          inst           imm                     rd br      a bsrc  ctr    wc rw m2r mw memop  il il32
    vecs[0]  = '{32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1,  3'b000, 1'b0, 2'b01, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0};
    vecs[1]  = '{32'hFE20CEE3, 64'hFFFF_FFFF_FFFF_FFFC, 5'd29, 3'b110, 1'b0, 2'b00, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0};
    vecs[2]  = '{32'hFE20FEE3, 64'hFFFF_FFFF_FFFF_FFFC, 5'd29, 3'b111, 1'b0, 2'b00, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0};
    vecs[3]  = '{32'h002080BB, 64'h0,                   5'd1,  3'b000, 1'b0, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 1'b1};
    vecs[4]  = '{32'h0080C183, 64'h8,                   5'd3,  3'b000, 1'b0, 2'b01, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 3'b001, 1'b0, 1'b0};
    vecs[5]  = '{32'h0020B823, 64'h10,                  5'd16, 3'b000, 1'b0, 2'b01, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'b110, 1'b0, 1'b1};
    vecs[6]  = '{32'h123452B7, 64'h0000_0000_1234_5000, 5'd5,  3'b000, 1'b0, 2'b01, 4'b0011, 1'b0, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0};
    vecs[7]  = '{32'h800002B7, 64'hFFFF_FFFF_8000_0000, 5'd5,  3'b000, 1'b0, 2'b01, 4'b0011, 1'b0, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0};
    vecs[8]  = '{32'h008000EF, 64'h8,                   5'd1,  3'b001, 1'b1, 2'b10, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0};
    vecs[9]  = '{32'h00008067, 64'h0,                   5'd0,  3'b010, 1'b1, 2'b10, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0};
    vecs[10] = '{32'h4020D1B3, 64'h0,                   5'd3,  3'b000, 1'b0, 2'b00, 4'b1101, 1'b0, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0};
    vecs[11] = '{32'h4210D093, 64'h421,                 5'd1,  3'b000, 1'b0, 2'b01, 4'b1101, 1'b0, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 1'b1};
    vecs[12] = '{32'h00100073, 64'h0,                   5'd0,  3'b000, 1'b0, 2'b00, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0};
    vecs[13] = '{32'hFFFFFFFF, 64'h0,                   5'd31, 3'b000, 1'b0, 2'b00, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 1'b1, 1'b1};
    vecs[14] = '{32'h402081B3, 64'h0,                   5'd3,  3'b000, 1'b0, 2'b00, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0};
    vecs[15] = '{32'hFFF0C113, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2,  3'b000, 1'b0, 2'b01, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0};
    vecs[16] = '{32'h00001097, 64'h1000,                5'd1,  3'b000, 1'b1, 2'b01, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0};
    vecs[17] = '{32'h0020A223, 64'h4,                   5'd4,  3'b000, 1'b0, 2'b01, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'b100, 1'b0, 1'b0};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; pc = '0; inst = '0;
    step(); step();
    chk("rst.valid", 64'(valid), 64'd0);
    chk("rst.ready", 64'(ready), 64'd1);
    chk("rst.count", 64'(cnt), 64'd0);
    chk("rst.ctr", 64'(ctr), 64'hF);
    chk("rst.memop", 64'(memop), 64'h7);
    chk("rst.imm", imm, 64'd0);
    rst_n = 1'b1;
    step();

    for (int k = 0; k < NV; k++) begin
      vec_t v;
      logic [63:0] pcv;
      v   = vecs[k];
      pcv = 64'h8000_0000 + 64'(k * 4);
      in_valid = 1'b1; inst = v.inst; pc = pcv; out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      chk($sformatf("v%0d.valid", k), 64'(valid), 64'd1);
      chk($sformatf("v%0d.count", k), 64'(cnt), 64'd1);
      chk($sformatf("v%0d.pc", k), opc, pcv);
      chk($sformatf("v%0d.imm", k), imm, v.imm);
      chk($sformatf("v%0d.rd", k), 64'(rd), 64'(v.rd));
      chk($sformatf("v%0d.ra", k), 64'(ra), 64'(v.inst[19:15]));
      chk($sformatf("v%0d.rb", k), 64'(rb), 64'(v.inst[24:20]));
      chk($sformatf("v%0d.branch", k), 64'(br), 64'(v.br));
      chk($sformatf("v%0d.asrc", k), 64'(asrc), 64'(v.asrc));
      chk($sformatf("v%0d.bsrc", k), 64'(bsrc), 64'(v.bsrc));
      chk($sformatf("v%0d.ctr", k), 64'(ctr), 64'(v.ctr));
      chk($sformatf("v%0d.wcut", k), 64'(wcut), 64'(v.wcut));
      chk($sformatf("v%0d.regwr", k), 64'(regwr), 64'(v.regwr));
      chk($sformatf("v%0d.memtoreg", k), 64'(m2r), 64'(v.m2r));
      chk($sformatf("v%0d.memwr", k), 64'(memwr), 64'(v.memwr));
      chk($sformatf("v%0d.memop", k), 64'(memop), 64'(v.memop));
      chk($sformatf("v%0d.illegal", k), 64'(ill), 64'(v.ill));
      chk($sformatf("v%0d.rv32_illegal", k), 64'(ill32), 64'(v.ill32));
      chk($sformatf("v%0d.rv32_regwr", k), 64'(regwr32), v.ill32 ? 64'd0 : 64'(v.regwr));
      chk($sformatf("v%0d.rv32_ctr", k), 64'(ctr32), v.ill32 ? 64'hF : 64'(v.ctr));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk($sformatf("v%0d.drained", k), 64'(valid), 64'd0);
    end

    // Backpressure: third beat must be refused while full.
    in_valid = 1'b1; out_ready = 1'b0; inst = 32'h00000013;
    pc = 64'h100; step();
    pc = 64'h104; step();
    chk("full.count", 64'(cnt), 64'd2);
    chk("full.ready", 64'(ready), 64'd0);
    pc = 64'h108; out_ready = 1'b1; step();
    chk("full.pop_no_push.count", 64'(cnt), 64'd1);
    chk("full.pop_no_push.pc", opc, 64'h104);
    // Simultaneous push and pop keeps occupancy.
    pc = 64'h10C; step();
    chk("pushpop.count", 64'(cnt), 64'd1);
    chk("pushpop.pc", opc, 64'h10C);
    in_valid = 1'b0; step();
    chk("drain.valid", 64'(valid), 64'd0);
    chk("drain.count", 64'(cnt), 64'd0);

    // Flush with a concurrent push and pop.
    in_valid = 1'b1; out_ready = 1'b0;
    pc = 64'h200; step();
    pc = 64'h204; step();
    chk("preflush.count", 64'(cnt), 64'd2);
    flush = 1'b1; pc = 64'h208; out_ready = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush.valid", 64'(valid), 64'd0);
    chk("flush.count", 64'(cnt), 64'd0);
    chk("flush.ready", 64'(ready), 64'd1);
    step();
    chk("flush.nostore", 64'(valid), 64'd0);
    in_valid = 1'b1; pc = 64'h20C; step();
    in_valid = 1'b0;
    chk("postflush.pc", opc, 64'h20C);
    chk("postflush.count", 64'(cnt), 64'd1);

    // Asynchronous reset mid-operation.
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst.valid", 64'(valid), 64'd0);
    chk("async_rst.count", 64'(cnt), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    in_valid = 1'b1; pc = 64'h300; inst = 32'hFFF00093; step();
    in_valid = 1'b0;
    chk("post_rst.pc", opc, 64'h300);
    chk("post_rst.count", 64'(cnt), 64'd1);
    chk("post_rst.imm", imm, 64'hFFFF_FFFF_FFFF_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
